// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - exception source indices, cause codes, vector offsets and FSM encoding
package exc_pkg;

    localparam int EXC_W           = 12;
    localparam int EXC_IADDR_ILL   = 0;
    localparam int EXC_IADDR_MISS  = 1;
    localparam int EXC_IADDR_INV   = 2;
    localparam int EXC_DADDR_ILL   = 3;
    localparam int EXC_DADDR_MISS  = 4;
    localparam int EXC_DADDR_INV   = 5;
    localparam int EXC_DADDR_DIRTY = 6;
    localparam int EXC_SYSCALL     = 7;
    localparam int EXC_RI          = 8;
    localparam int EXC_CPU         = 9;
    localparam int EXC_OV          = 10;
    localparam int EXC_ERET        = 11;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_MOD  = 5'h01;
    localparam logic [4:0] EXCCODE_TLBL = 5'h02;
    localparam logic [4:0] EXCCODE_TLBS = 5'h03;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_RI   = 5'h0A;
    localparam logic [4:0] EXCCODE_CPU  = 5'h0B;
    localparam logic [4:0] EXCCODE_OV   = 5'h0C;

    localparam logic [31:0] VEC_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_GENERAL = 32'h0000_0180;
    localparam logic [31:0] VEC_INT     = 32'h0000_0200;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef struct packed {
        logic [31:0] new_pc;
        logic [31:0] epc;
        logic [4:0]  code;
        logic [31:0] badv;
        logic [7:0]  asid;
        logic        wr_exp;
        logic        clean_exl;
        logic        badv_we;
        logic        asid_we;
    } commit_t;

    // Index of the highest-priority (lowest-numbered) set source; EXC_W when none.
    function automatic int lowest_set(input logic [EXC_W-1:0] v);
        int idx;
        idx = EXC_W;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - per-bit multi-stage synchroniser with asynchronous clear
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - registered exception/interrupt prioritiser with CP0 commit pulse and flush drain
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int          N_HW_INT      = 6,
    parameter int          N_SW_INT      = 2,
    parameter int          SYNC_STAGES   = 2,
    parameter int          FLUSH_CYCLES  = 2,
    parameter logic [31:0] BOOT_EXP_BASE = 32'hBFC0_0200
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_HW_INT-1:0]          hw_int_raw,
    input  logic [N_SW_INT-1:0]          sw_int,
    input  logic [N_HW_INT+N_SW_INT-1:0] int_mask,
    input  logic                         allow_int,
    input  logic                         is_real_inst,
    input  logic [EXC_W-1:0]             exc_src,
    input  logic                         data_we,
    input  logic [31:0]                  pc_value,
    input  logic                         in_delayslot,
    input  logic [31:0]                  mem_access_vaddr,
    input  logic [7:0]                   if_asid,
    input  logic [7:0]                   mm_asid,
    input  logic [19:0]                  ebase_in,
    input  logic [31:0]                  epc_in,
    input  logic                         special_int_vec,
    input  logic                         boot_exp_vec,
    input  logic                         if_exl,
    input  logic                         mm_exl,
    output logic                         flush,
    output logic                         new_pc_valid,
    output logic [31:0]                  exception_new_pc,
    output logic                         cp0_wr_exp,
    output logic                         cp0_clean_exl,
    output logic [31:0]                  exp_epc,
    output logic [4:0]                   exp_code,
    output logic                         cp0_badv_we,
    output logic [31:0]                  exp_bad_vaddr,
    output logic                         cp0_exp_asid_we,
    output logic [7:0]                   exp_asid,
    output logic [N_HW_INT+N_SW_INT-1:0] int_pending,
    output logic                         busy
);

    localparam int NI = N_HW_INT + N_SW_INT;
    localparam int CW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CW-1:0] DRAIN_LOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : CW'(0);

    logic [N_HW_INT-1:0] hw_sync;
    logic [NI-1:0]       int_pending_d, int_pending_q;
    logic                int_req, event_det;
    logic [31:0]         base;
    logic [1:0]          state_d, state_q;
    logic [CW-1:0]       cnt_d, cnt_q;
    commit_t             commit_d, commit_q;
    int                  src_idx;

    int_sync #(.WIDTH(N_HW_INT), .STAGES(SYNC_STAGES)) u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (hw_int_raw),
        .sync_o  (hw_sync)
    );

    assign int_pending_d = {hw_sync, sw_int} & int_mask;
    assign int_req       = is_real_inst && allow_int && (|int_pending_d);
    assign event_det     = int_req || (|exc_src);
    assign base          = boot_exp_vec ? BOOT_EXP_BASE : {ebase_in, 12'h000};
    assign src_idx       = lowest_set(exc_src);

    always_comb begin
        commit_d        = '0;
        commit_d.epc    = in_delayslot ? pc_value - 32'd4 : pc_value;
        commit_d.new_pc = base + VEC_GENERAL;
        commit_d.wr_exp = 1'b1;
        if (int_req) begin
            commit_d.code = EXCCODE_INT;
            if (special_int_vec) commit_d.new_pc = base + VEC_INT;
        end else begin
            // Fetch faults report the PC, data faults the access address.
            if (src_idx <= EXC_IADDR_INV) begin
                commit_d.badv_we = 1'b1;
                commit_d.badv    = pc_value;
                commit_d.asid    = if_asid;
            end else if (src_idx <= EXC_DADDR_DIRTY) begin
                commit_d.badv_we = 1'b1;
                commit_d.badv    = mem_access_vaddr;
                commit_d.asid    = mm_asid;
            end
            case (src_idx)
                EXC_IADDR_ILL: commit_d.code = EXCCODE_ADEL;
                EXC_IADDR_MISS, EXC_IADDR_INV: begin
                    commit_d.code    = EXCCODE_TLBL;
                    commit_d.asid_we = 1'b1;
                    if (src_idx == EXC_IADDR_MISS && !if_exl) commit_d.new_pc = base + VEC_REFILL;
                end
                EXC_DADDR_ILL: commit_d.code = data_we ? EXCCODE_ADES : EXCCODE_ADEL;
                EXC_DADDR_MISS, EXC_DADDR_INV: begin
                    commit_d.code    = data_we ? EXCCODE_TLBS : EXCCODE_TLBL;
                    commit_d.asid_we = 1'b1;
                    if (src_idx == EXC_DADDR_MISS && !mm_exl) commit_d.new_pc = base + VEC_REFILL;
                end
                EXC_DADDR_DIRTY: begin
                    commit_d.code    = EXCCODE_MOD;
                    commit_d.asid_we = 1'b1;
                end
                EXC_SYSCALL: commit_d.code = EXCCODE_SYS;
                EXC_RI:      commit_d.code = EXCCODE_RI;
                EXC_CPU:     commit_d.code = EXCCODE_CPU;
                EXC_OV:      commit_d.code = EXCCODE_OV;
                EXC_ERET: begin
                    commit_d.code      = EXCCODE_INT;
                    commit_d.wr_exp    = 1'b0;
                    commit_d.clean_exl = 1'b1;
                    commit_d.new_pc    = epc_in;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (event_det) state_d = ST_COMMIT;
            ST_COMMIT: begin
                if (FLUSH_CYCLES == 1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            commit_q      <= '0;
            int_pending_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            int_pending_q <= int_pending_d;
            if (state_q == ST_IDLE && event_det) commit_q <= commit_d;
        end
    end

    assign new_pc_valid     = (state_q == ST_COMMIT);
    assign flush            = (state_q != ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign cp0_wr_exp       = new_pc_valid && commit_q.wr_exp;
    assign cp0_clean_exl    = new_pc_valid && commit_q.clean_exl;
    assign cp0_badv_we      = new_pc_valid && commit_q.badv_we;
    assign cp0_exp_asid_we  = new_pc_valid && commit_q.asid_we;
    assign exception_new_pc = commit_q.new_pc;
    assign exp_epc          = commit_q.epc;
    assign exp_code         = commit_q.code;
    assign exp_bad_vaddr    = commit_q.badv;
    assign exp_asid         = commit_q.asid;
    assign int_pending      = int_pending_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - scoreboard bench for exception_ctrl
module tb_exception_ctrl;

    localparam int FC   = 3;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hw_int_raw;
    logic [1:0]  sw_int;
    logic [7:0]  int_mask;
    logic        allow_int, is_real_inst, data_we, in_delayslot;
    logic [11:0] exc_src;
    logic [31:0] pc_value, mem_access_vaddr, epc_in;
    logic [7:0]  if_asid, mm_asid;
    logic [19:0] ebase_in;
    logic        special_int_vec, boot_exp_vec, if_exl, mm_exl;
    logic        flush, new_pc_valid, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we, busy;
    logic [31:0] exception_new_pc, exp_epc, exp_bad_vaddr;
    logic [4:0]  exp_code;
    logic [7:0]  exp_asid, int_pending;

    exception_ctrl #(.SYNC_STAGES(SYNC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .hw_int_raw(hw_int_raw), .sw_int(sw_int), .int_mask(int_mask),
        .allow_int(allow_int), .is_real_inst(is_real_inst), .exc_src(exc_src), .data_we(data_we),
        .pc_value(pc_value), .in_delayslot(in_delayslot), .mem_access_vaddr(mem_access_vaddr),
        .if_asid(if_asid), .mm_asid(mm_asid), .ebase_in(ebase_in), .epc_in(epc_in),
        .special_int_vec(special_int_vec), .boot_exp_vec(boot_exp_vec), .if_exl(if_exl), .mm_exl(mm_exl),
        .flush(flush), .new_pc_valid(new_pc_valid), .exception_new_pc(exception_new_pc),
        .cp0_wr_exp(cp0_wr_exp), .cp0_clean_exl(cp0_clean_exl), .exp_epc(exp_epc), .exp_code(exp_code),
        .cp0_badv_we(cp0_badv_we), .exp_bad_vaddr(exp_bad_vaddr), .cp0_exp_asid_we(cp0_exp_asid_we),
        .exp_asid(exp_asid), .int_pending(int_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  code;
        logic [31:0] epc;
        bit          chk_epc;
        logic [3:0]  pulses;
        logic [31:0] badv;
        logic [7:0]  asid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   fl;
    int   lat;
    int   cyc;
    int   tstamp[3];
    int   nseen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // pulses = {wr_exp, clean_exl, badv_we, asid_we}
    task automatic push(input logic [31:0] pc, input logic [4:0] code, input logic [31:0] epc,
                        input bit chk_epc, input logic [3:0] pulses, input logic [31:0] badv,
                        input logic [7:0] asid);
        exp_t e;
        e.pc = pc; e.code = code; e.epc = epc; e.chk_epc = chk_epc;
        e.pulses = pulses; e.badv = badv; e.asid = asid;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (new_pc_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("new_pc", exception_new_pc, mon_e.pc);
                    chk("exp_code", {27'd0, exp_code}, {27'd0, mon_e.code});
                    if (mon_e.chk_epc) chk("exp_epc", exp_epc, mon_e.epc);
                    chk("cp0_pulses", {28'd0, cp0_wr_exp, cp0_clean_exl, cp0_badv_we, cp0_exp_asid_we},
                        {28'd0, mon_e.pulses});
                    if (mon_e.pulses[1]) chk("bad_vaddr", exp_bad_vaddr, mon_e.badv);
                    if (mon_e.pulses[0]) chk("asid", {24'd0, exp_asid}, {24'd0, mon_e.asid});
                end
            end else if (cp0_wr_exp || cp0_clean_exl || cp0_badv_we || cp0_exp_asid_we) begin
                chk("stray_pulse", 32'd1, 32'd0);
            end
        end
    end

    task automatic run_exc(input logic [11:0] src, output int flen);
        exc_src = src;
        @(negedge clk);
        exc_src = '0;
        flen = 0;
        for (int i = 0; i < 20 && flush; i++) begin
            flen++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic any_out();
        return |{flush, new_pc_valid, exception_new_pc, cp0_wr_exp, cp0_clean_exl, exp_epc, exp_code,
                 cp0_badv_we, exp_bad_vaddr, cp0_exp_asid_we, exp_asid, int_pending, busy};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; hw_int_raw = '0; sw_int = '0; int_mask = '0; allow_int = 0; is_real_inst = 0;
        exc_src = '0; data_we = 0; pc_value = '0; in_delayslot = 0; mem_access_vaddr = '0;
        if_asid = '0; mm_asid = '0; ebase_in = '0; epc_in = '0; special_int_vec = 0;
        boot_exp_vec = 0; if_exl = 0; mm_exl = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {31'd0, any_out()}, 32'd0);
        rst_n = 1'b1;
        ebase_in = 20'h80000; is_real_inst = 1;
        @(negedge clk);

        // Overflow in a delay slot
        pc_value = 32'h8000_1004; in_delayslot = 1;
        push(32'h8000_0180, 5'h0C, 32'h8000_1000, 1, 4'b1000, 0, 0);
        run_exc(12'h400, fl);
        chk("ov_flush_len", fl, FC);
        in_delayslot = 0;

        // Data TLB miss on a store, EXL clear -> refill vector
        pc_value = 32'h8000_1010; data_we = 1; mm_exl = 0;
        mem_access_vaddr = 32'h0040_0010; mm_asid = 8'h5A;
        push(32'h8000_0000, 5'h03, 32'h8000_1010, 1, 4'b1011, 32'h0040_0010, 8'h5A);
        run_exc(12'h010, fl);

        // Fetch TLB miss with EXL set -> general vector
        data_we = 0; pc_value = 32'h8000_3000; if_exl = 1; if_asid = 8'h33;
        push(32'h8000_0180, 5'h02, 32'h8000_3000, 1, 4'b1011, 32'h8000_3000, 8'h33);
        run_exc(12'h002, fl);
        if_exl = 0;

        // Store address error
        data_we = 1; mem_access_vaddr = 32'h0000_0003;
        push(32'h8000_0180, 5'h05, 32'h8000_3000, 1, 4'b1010, 32'h0000_0003, 0);
        run_exc(12'h008, fl);
        data_we = 0;

        // Syscall with BEV=1
        boot_exp_vec = 1;
        push(32'hBFC0_0380, 5'h08, 32'h8000_3000, 1, 4'b1000, 0, 0);
        run_exc(12'h080, fl);
        boot_exp_vec = 0;

        // ERET
        epc_in = 32'h8000_2000;
        push(32'h8000_2000, 5'h00, 0, 0, 4'b0100, 0, 0);
        run_exc(12'h800, fl);

        // Interrupt beats exceptions; exception re-presents after masking
        pc_value = 32'h8000_4000; sw_int = 2'b01; int_mask = 8'h01; allow_int = 1;
        push(32'h8000_0180, 5'h00, 32'h8000_4000, 1, 4'b1000, 0, 0);
        push(32'h8000_0180, 5'h04, 32'h8000_4000, 1, 4'b1010, 32'h8000_4000, 0);
        exc_src = 12'h881;
        @(negedge clk);
        chk("sw_int_pending", {24'd0, int_pending}, 32'h01);
        int_mask = 8'h00;
        nseen = 0;
        for (int i = 0; i < 20 && nseen == 0; i++) begin
            @(negedge clk);
            if (new_pc_valid) nseen = 1;
        end
        chk("adel_after_int", nseen, 1);
        exc_src = '0; sw_int = '0; allow_int = 0;
        wait_idle();

        // Hardware interrupt through the synchroniser, IV=1
        pc_value = 32'h8000_5000; int_mask = 8'h04; allow_int = 1; special_int_vec = 1;
        push(32'h8000_0200, 5'h00, 32'h8000_5000, 1, 4'b1000, 0, 0);
        hw_int_raw = 6'h01;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (new_pc_valid) break;
        end
        chk("hw_int_latency", lat, SYNC + 1);
        chk("hw_int_pending", {24'd0, int_pending}, 32'h04);
        allow_int = 0; hw_int_raw = '0; special_int_vec = 0;
        wait_idle();

        // Back-to-back: source held through drain
        for (int k = 0; k < 3; k++) push(32'h8000_0180, 5'h0C, 32'h8000_5000, 1, 4'b1000, 0, 0);
        exc_src = 12'h400;
        nseen = 0; cyc = 0;
        while (nseen < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (new_pc_valid) begin
                tstamp[nseen] = cyc;
                nseen++;
            end
        end
        exc_src = '0;
        chk("b2b_count", nseen, 3);
        if (nseen == 3) begin
            chk("b2b_gap0", tstamp[1] - tstamp[0], FC + 1);
            chk("b2b_gap1", tstamp[2] - tstamp[1], FC + 1);
        end
        wait_idle();

        // Reset mid-drain
        push(32'h8000_0180, 5'h08, 32'h8000_5000, 1, 4'b1000, 0, 0);
        exc_src = 12'h080;
        @(negedge clk);
        exc_src = '0;
        @(negedge clk);
        chk("drain_busy", {31'd0, busy & flush & ~new_pc_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_drain", {31'd0, any_out()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, flush, busy}, 32'd0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
